// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - sequential N-bit ALU, single-cycle logic/arith ops plus shift-add MUL
// Define ALU_SEQ_MUL_EN to build the multi-cycle MUL (ALUOp=111) path and MULT state.
module alu_nbit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  input  logic             BNegate,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Rezultati,
  output logic [WIDTH-1:0] RezultatiHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_NOR = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic             accept;
  logic             mul_start;
  logic             mul_last;

  // Accepted request is held here; the output stage consumes it one edge later.
  logic             pend_valid;
  logic [2:0]       pend_op;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic             pend_neg;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             ovf;
  logic             cry;
  logic             zero;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MULT} state_t;

  state_t             state;
  state_t             state_next;
  logic [SW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    accept     = 1'b0;
    mul_start  = 1'b0;
    mul_last   = 1'b0;
    case (state)
      IDLE: begin
        accept = Start;
        if (Start && (ALUOp == OP_MUL)) begin
          mul_start  = 1'b1;
          state_next = MULT;
        end
      end
      MULT: begin
        Busy = 1'b1;
        if (count == SW'(WIDTH - 1)) begin
          mul_last   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One multiplier bit per clock; product is complete on the edge that leaves MULT.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (mul_start) begin
      count  <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      prod   <= '0;
    end else if (Busy) begin
      count  <= count + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
    end
  end
`else
  assign Busy      = 1'b0;
  assign accept    = Start;
  assign mul_start = 1'b0;
  assign mul_last  = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      pend_valid <= 1'b0;
      pend_op    <= '0;
      pend_a     <= '0;
      pend_b     <= '0;
      pend_neg   <= 1'b0;
    end else begin
      pend_valid <= (accept && !mul_start) || mul_last;
      if (accept) begin
        pend_op  <= ALUOp;
        pend_a   <= A;
        pend_b   <= B;
        pend_neg <= BNegate;
      end
    end
  end

  always_comb begin
    b_eff  = pend_b ^ {WIDTH{pend_neg}};
    sum    = {1'b0, pend_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, pend_neg};
    res    = '0;
    res_hi = '0;
    ovf    = 1'b0;
    cry    = 1'b0;
    case (pend_op)
      OP_AND: res = pend_a & b_eff;
      OP_NOR: res = ~(pend_a | b_eff);
      OP_OR:  res = pend_a | b_eff;
      OP_XOR: res = pend_a ^ b_eff;
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        cry = sum[WIDTH];
        ovf = (pend_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != pend_a[WIDTH-1]);
      end
      // Direct signed compare stays correct where A-B would overflow.
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(pend_a) < $signed(pend_b))};
      OP_SHL: res = pend_a << pend_b[SW-1:0];
      default: begin
`ifdef ALU_SEQ_MUL_EN
        res    = prod[WIDTH-1:0];
        res_hi = prod[2*WIDTH-1:WIDTH];
        ovf    = |prod[2*WIDTH-1:WIDTH];
`endif
      end
    endcase
    zero = (res == '0) && (res_hi == '0);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Done        <= 1'b0;
      Rezultati   <= '0;
      RezultatiHi <= '0;
      Zero        <= 1'b0;
      Overflow    <= 1'b0;
      CarryOut    <= 1'b0;
    end else begin
      Done <= pend_valid;
      if (pend_valid) begin
        Rezultati   <= res;
        RezultatiHi <= res_hi;
        Zero        <= zero;
        Overflow    <= ovf;
        CarryOut    <= cry;
      end
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - table-driven bench for alu_nbit_seq (WIDTH=16)
module tb_alu_nbit_seq;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  ALUOp;
  logic        BNegate;
  logic        Busy;
  logic        Done;
  logic [15:0] Rezultati;
  logic [15:0] RezultatiHi;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;

  int checks = 0;
  int errors = 0;

  alu_nbit_seq #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .A(A), .B(B),
    .ALUOp(ALUOp), .BNegate(BNegate), .Busy(Busy), .Done(Done),
    .Rezultati(Rezultati), .RezultatiHi(RezultatiHi), .Zero(Zero),
    .Overflow(Overflow), .CarryOut(CarryOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  op;
    logic        neg;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [15:0] res, input logic [15:0] hi,
                         input logic z, input logic v, input logic c);
    chk({name, "_res"}, 64'(Rezultati), 64'(res));
    chk({name, "_hi"}, 64'(RezultatiHi), 64'(hi));
    chk({name, "_zero"}, 64'(Zero), 64'(z));
    chk({name, "_ovf"}, 64'(Overflow), 64'(v));
    chk({name, "_cry"}, 64'(CarryOut), 64'(c));
  endtask

  task automatic drive(input logic [2:0] op, input logic neg, input logic [15:0] a,
                       input logic [15:0] b);
    Start   = 1'b1;
    ALUOp   = op;
    BNegate = neg;
    A       = a;
    B       = b;
  endtask

  // Wait for Done after an accepting edge; returns edges elapsed (0 on timeout).
  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
    if (!Done) begin
      chk({name, "_timeout"}, 64'(Done), 64'd1);
      n = 0;
    end
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0]  = '{3'b000, 1'b0, 16'd13,    16'd7,     16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 1'b0, 16'd13,    16'd7,     16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b011, 1'b0, 16'd13,    16'd7,     16'h000A, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 1'b0, 16'd13,    16'd7,     16'hFFF0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 1'b1, 16'd13,    16'd7,     16'h0006, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b100, 1'b1, 16'd13,    16'd13,    16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{3'b100, 1'b0, 16'h0001,  16'h7FFF,  16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b101, 1'b0, 16'h8000,  16'h0001,  16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 1'b0, 16'h0003,  16'h0004,  16'h0030, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 1'b0, 16'h0001,  16'h8000,  16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 1'b1, 16'h8001,  16'h0011,  16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 1'b1, 16'd13,    16'd7,     16'h0008, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b100, 1'b1, 16'h8000,  16'h0001,  16'h7FFF, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{3'b100, 1'b0, 16'hFFFF,  16'h0001,  16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{3'b101, 1'b1, 16'h7FFF,  16'h8000,  16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'b101, 1'b0, 16'h8000,  16'h7FFF,  16'h0001, 1'b0, 1'b0, 1'b0};

    Reset_n = 1'b0;
    Start   = 1'b0;
    A       = '0;
    B       = '0;
    ALUOp   = '0;
    BNegate = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk_out("rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].neg, vecs[i].a, vecs[i].b);
      tick();
      Start = 1'b0;
      A     = 16'hA5A5;
      B     = 16'h5A5A;
      chk($sformatf("v%0d_early", i), 64'(Done), 64'd0);
      chk($sformatf("v%0d_busy", i), 64'(Busy), 64'd0);
      tick();
      chk($sformatf("v%0d_done", i), 64'(Done), 64'd1);
      chk_out($sformatf("v%0d", i), vecs[i].res, 16'h0000, vecs[i].z, vecs[i].v, vecs[i].c);
      tick();
      chk($sformatf("v%0d_pulse", i), 64'(Done), 64'd0);
      chk_out($sformatf("v%0d_hold", i), vecs[i].res, 16'h0000, vecs[i].z, vecs[i].v, vecs[i].c);
    end

    // Back-to-back single-cycle ops: second Start lands on the first Done edge.
    drive(3'b000, 1'b0, 16'd13, 16'd7);
    tick();
    drive(3'b010, 1'b0, 16'd13, 16'd7);
    tick();
    Start = 1'b0;
    chk("b2b_done1", 64'(Done), 64'd1);
    chk("b2b_res1", 64'(Rezultati), 64'h0005);
    tick();
    chk("b2b_done2", 64'(Done), 64'd1);
    chk("b2b_res2", 64'(Rezultati), 64'h000F);
    tick();

`ifdef ALU_SEQ_MUL_EN
    drive(3'b111, 1'b0, 16'h00FF, 16'h0101);
    tick();
    Start = 1'b0;
    A     = 16'hFFFF;
    B     = 16'hFFFF;
    chk("mul1_busy", 64'(Busy), 64'd1);
    wait_done("mul1", n);
    chk("mul1_lat", 64'(n), 64'd17);
    chk_out("mul1", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mul1_pulse", 64'(Done), 64'd0);

    // Start with ADD operands while busy must be ignored.
    drive(3'b111, 1'b0, 16'h8000, 16'h0004);
    tick();
    tick();
    drive(3'b100, 1'b0, 16'h0001, 16'h0001);
    for (int i = 0; i < 4; i++) tick();
    chk("mul2_busy", 64'(Busy), 64'd1);
    Start = 1'b0;
    wait_done("mul2", n);
    chk("mul2_lat", 64'(n), 64'd12);
    chk_out("mul2", 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mul2_noadd", 64'(Done), 64'd0);
    chk("mul2_hold", 64'(Rezultati), 64'h0000);

    // MUL followed by AND accepted on the MUL Done edge.
    drive(3'b111, 1'b0, 16'h0003, 16'h0005);
    tick();
    Start = 1'b0;
    n = 0;
    while (Busy && n < 40) begin
      tick();
      n++;
    end
    chk("mul3_busylen", 64'(n), 64'd16);
    drive(3'b000, 1'b0, 16'd13, 16'd7);
    tick();
    Start = 1'b0;
    chk("mul3_done", 64'(Done), 64'd1);
    chk_out("mul3", 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mul3_and_done", 64'(Done), 64'd1);
    chk("mul3_and_res", 64'(Rezultati), 64'h0005);
    tick();

    // Reset on the 5th MUL cycle aborts without Done.
    drive(3'b111, 1'b0, 16'h0102, 16'h0304);
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("mrst_busy", 64'(Busy), 64'd0);
    chk("mrst_done", 64'(Done), 64'd0);
    chk_out("mrst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | Done | Busy;
    end
    chk("mrst_quiet", 64'(seen), 64'd0);
`else
    drive(3'b111, 1'b0, 16'h00FF, 16'h0101);
    tick();
    Start = 1'b0;
    chk("nomul_busy", 64'(Busy), 64'd0);
    tick();
    chk("nomul_done", 64'(Done), 64'd1);
    chk_out("nomul", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 16'h0001, 16'h7FFF);
    tick();
    Start = 1'b0;
    tick();
    chk("nomul_add", 64'(Rezultati), 64'h8000);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("nrst_done", 64'(Done), 64'd0);
    chk_out("nrst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
